iter_div_unit: RTL and testbench
================================

// Module: iter_div_unit
// PURPOSE
//  Multicycle RV32M divider (DIV/DIVU/REM/REMU) sitting in the EX stage.
//  Produces the busy/done handshake that the hazard unit consumes as busyA/doneA.
//  Radix-2 restoring divider: one quotient bit per cycle.
//  Honours pipeline flush by aborting the in-flight operation.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk     in   1     clock, rising edge
//  rst     in   1     reset, asynchronous, active-high
//  start   in   1     EX holds a divide op; stays high while the pipeline is stalled
//  flush   in   1     abort the current op (branch/jump redirect from EX)
//  op      in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//  a       in   XLEN  dividend (rs1), sampled when the op is accepted
//  b       in   XLEN  divisor (rs2), sampled when the op is accepted
//  result  out  XLEN  quotient or remainder; held stable until the next accept
//  busy    out  1     stall request to the hazard unit
//  done    out  1     one-cycle pulse: result valid
// BEHAVIOUR
//  Reset: state=IDLE; result=0; busy=0; done=0; internal registers cleared.
//   Reset mid-operation discards the op; done is not asserted.
//  States and transitions:
//   IDLE -> CALC  on start & !flush (accept): latch op, |a|, |b|,
//    and the sign flags; iteration counter=XLEN-1.
//   CALC -> DONE  after XLEN iterations (counter reaches 0).
//   CALC -> IDLE  on flush.
//   DONE -> IDLE  unconditionally. start is ignored in DONE, because the same
//    instruction is still in EX; this prevents a re-issue.
//  busy = (IDLE & start & !flush) | CALC, combinational.
//   busy rises in the accept cycle, so EX does not advance.
//   busy is low in DONE, so the pipeline advances and captures result.
//  done is registered; high only in the DONE cycle.
//  Latency with accept at cycle 0: busy high cycles 0..XLEN; done=1 at cycle XLEN+1.
//  Iteration step: rem = {rem[XLEN-2:0], q[XLEN-1]}; trial = rem - |b|.
//   If trial >= 0 (no borrow): rem = trial, shift in quotient bit 1; else shift in 0.
//   Arithmetic is XLEN+1 bits wide to catch the borrow.
//  Sign fix (DIV/REM only): quotient is negated if sign(a) != sign(b);
//   remainder takes the sign of a.
//  Special cases (forced at completion, mandatory):
//   b==0:                    quotient = all-ones; remainder = a
//   DIV/REM, a=0x80000000, b=-1 (overflow): quotient = 0x80000000; remainder = 0
//  Flush in CALC: return to IDLE next edge; busy=0 from the next cycle;
//   no done; result unchanged.
//  Flush coincident with start in IDLE: no accept; busy=0.
//  Flush in DONE: done still pulses; the hazard unit discards it.
//  A new start in the cycle after DONE (back-to-back divides) is accepted normally.
// CONFIGURATION
//  DIV_SPECIAL_FASTPATH_EN defined:
//   - Divide-by-zero and overflow are detected in the accept cycle;
//     the FSM goes IDLE->DONE directly.
//   - busy is high in cycle 0 only; done and result are valid at cycle 1.
//  Undefined:
//   - Special cases run the full XLEN iterations.
//   - Results are still forced to the mandated values at completion.
// TESTING
//  DIVU a=100, b=7 -> busy cycles 0..32; done at cycle 33; result=14.
//  REM a=-7, b=2 -> result=0xFFFFFFFF (-1).
//  DIV a=-7, b=2 -> result=0xFFFFFFFD (-3).
//  DIVU a=5, b=0 -> 0xFFFFFFFF.
//  REMU a=5, b=0 -> 5.
//   With FASTPATH_EN: done at cycle 1. Without: done at cycle 33.
//  DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
//  REM 0x80000000 / 0xFFFFFFFF -> 0.
//  start held high through DONE -> exactly one done pulse; no second busy.
//  flush at cycle 10 -> busy=0 at cycle 11, no done, result unchanged.
//  rst asserted at cycle 5 -> outputs 0 immediately.

Source files
------------

// File: rtl/iter_div_unit_if.sv
// Divider handshake bundle between the EX stage (master) and the
// iterative divider (slave): op request, flush, result and busy/done.
interface iter_div_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic            flush;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] result;
   logic            busy;
   logic            done;

   modport master (
      output start, flush, op, a, b,
      input  result, busy, done
   );

   modport slave (
      input  start, flush, op, a, b,
      output result, busy, done
   );
endinterface

// File: rtl/iter_div_unit.sv
// iter_div_unit: multicycle RV32M divider (DIV/DIVU/REM/REMU), radix-2
// restoring, one quotient bit per cycle on magnitudes with a sign fix at
// the end. busy stalls the pipeline from the accept cycle to the last
// iteration; done pulses for one cycle with result valid.
// Optional build macro DIV_SPECIAL_FASTPATH_EN: divide-by-zero and signed
// overflow skip the iterations and complete one cycle after accept.
module iter_div_unit #(
   parameter int unsigned XLEN = 32
) (
   input logic               clk,
   input logic               rst,
   iter_div_unit_if.slave    div
);

   localparam int unsigned CW = $clog2(XLEN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q,  state_d;
   logic [CW-1:0]   cnt_q,    cnt_d;
   logic [1:0]      op_q,     op_d;
   logic            q_neg_q,  q_neg_d;
   logic            r_neg_q,  r_neg_d;
   logic            divz_q,   divz_d;
   logic            ovf_q,    ovf_d;
   logic [XLEN-1:0] a_q,      a_d;
   logic [XLEN-1:0] dvsr_q,   dvsr_d;
   logic [XLEN-1:0] quo_q,    quo_d;
   logic [XLEN-1:0] rem_q,    rem_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            done_q,   done_d;

   logic            accept;
   logic            is_signed;
   logic            a_sign;
   logic            b_sign;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   logic            b_zero;
   logic            in_ovf;

   logic [XLEN:0]   shifted;
   logic            no_borrow;
   logic [XLEN-1:0] rem_step;
   logic [XLEN-1:0] quo_step;

   // Applies sign correction and the mandated divide-by-zero / overflow values.
   function automatic logic [XLEN-1:0] fix_result(
      input logic [1:0]      f_op,
      input logic            qneg,
      input logic            rneg,
      input logic            divz,
      input logic            ovf,
      input logic [XLEN-1:0] a_orig,
      input logic [XLEN-1:0] q,
      input logic [XLEN-1:0] r
   );
      logic [XLEN-1:0] quo;
      logic [XLEN-1:0] rmd;
      quo = qneg ? (~q + 1'b1) : q;
      rmd = rneg ? (~r + 1'b1) : r;
      if (divz) begin
         quo = '1;
         rmd = a_orig;
      end else if (ovf) begin
         quo = {1'b1, {(XLEN-1){1'b0}}};
         rmd = '0;
      end
      return f_op[1] ? rmd : quo;
   endfunction

   assign accept    = (state_q == S_IDLE) && div.start && !div.flush;
   assign is_signed = !div.op[0];
   assign a_sign    = is_signed && div.a[XLEN-1];
   assign b_sign    = is_signed && div.b[XLEN-1];
   assign abs_a     = a_sign ? (~div.a + 1'b1) : div.a;
   assign abs_b     = b_sign ? (~div.b + 1'b1) : div.b;
   assign b_zero    = (div.b == '0);
   assign in_ovf    = is_signed && (div.a == {1'b1, {(XLEN-1){1'b0}}}) && (div.b == '1);

   // Partial remainder is shifted into XLEN+1 bits so a divisor with its
   // MSB set (DIVU) cannot lose the top bit of the shifted remainder.
   assign shifted   = {rem_q, quo_q[XLEN-1]};
   assign no_borrow = (shifted >= {1'b0, dvsr_q});
   assign rem_step  = no_borrow ? XLEN'(shifted - {1'b0, dvsr_q}) : XLEN'(shifted);
   assign quo_step  = {quo_q[XLEN-2:0], no_borrow};

   assign div.busy   = accept || (state_q == S_CALC);
   assign div.done   = done_q;
   assign div.result = result_q;

   // FSM, operand capture, iteration step and completion.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      divz_d   = divz_q;
      ovf_d    = ovf_q;
      a_d      = a_q;
      dvsr_d   = dvsr_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = div.op;
               q_neg_d = a_sign ^ b_sign;
               r_neg_d = a_sign;
               divz_d  = b_zero;
               ovf_d   = in_ovf;
               a_d     = div.a;
               dvsr_d  = abs_b;
               quo_d   = abs_a;
               rem_d   = '0;
               cnt_d   = CW'(XLEN-1);
`ifdef DIV_SPECIAL_FASTPATH_EN
               if (b_zero || in_ovf) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  result_d = fix_result(div.op, 1'b0, 1'b0, b_zero, in_ovf,
                                        div.a, '0, '0);
               end else begin
                  state_d = S_CALC;
               end
`else
               state_d = S_CALC;
`endif
            end
         end
         S_CALC: begin
            if (div.flush) begin
               state_d = S_IDLE;
            end else begin
               quo_d = quo_step;
               rem_d = rem_step;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  result_d = fix_result(op_q, q_neg_q, r_neg_q, divz_q, ovf_q,
                                        a_q, quo_step, rem_step);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         divz_q   <= 1'b0;
         ovf_q    <= 1'b0;
         a_q      <= '0;
         dvsr_q   <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         divz_q   <= divz_d;
         ovf_q    <= ovf_d;
         a_q      <= a_d;
         dvsr_q   <= dvsr_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: expected results are queued when an op
// is issued and popped when done pulses; latency, busy length, flush and
// asynchronous reset behaviour are checked alongside.
module tb_iter_div_unit;
   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic rst;

   iter_div_unit_if #(.XLEN(XLEN)) bus();

   iter_div_unit #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .div (bus)
   );

   always #5 clk = ~clk;

   int unsigned passed = 0;
   int unsigned total  = 0;
   logic [31:0] sb_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         2'd0:    return $signed(a) / $signed(b);
         2'd1:    return a / b;
         2'd2:    return $signed(a) % $signed(b);
         default: return a % b;
      endcase
   endfunction

   function automatic int lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_SPECIAL_FASTPATH_EN
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
      return 33;
   endfunction

   // Entered just after a rising edge; leaves just after the edge ending DONE.
   task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
      int          exp_lat;
      int          done_at;
      int          cyc;
      int          busy_cycles;
      logic [31:0] res_at_done;
      logic [31:0] exp;
      exp_lat     = lat(op, a, b);
      done_at     = -1;
      cyc         = 0;
      busy_cycles = 0;
      res_at_done = '0;
      sb_q.push_back(model(op, a, b));
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      while (done_at < 0 && cyc < 100) begin
         @(negedge clk);
         if (bus.busy) busy_cycles++;
         if (bus.done) begin
            done_at     = cyc;
            res_at_done = bus.result;
            check({tag, " busy_in_done"}, 32'(bus.busy), 32'd0);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.start = 1'b0;
      check({tag, " done_cycle"}, done_at, exp_lat);
      check({tag, " busy_cycles"}, busy_cycles, exp_lat);
      exp = sb_q.pop_front();
      check({tag, " result"}, res_at_done, exp);
   endtask

   initial begin
      int          dones;
      logic [31:0] held;
      logic [31:0] ra;
      logic [31:0] rb;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = 2'd0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset result", bus.result, 32'd0);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_div(2'd1, 32'd100, 32'd7, "divu_100_7");
      @(negedge clk);
      check("single_done_pulse", 32'(bus.done), 32'd0);
      check("no_second_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;

      // Back-to-back issues.
      run_div(2'd2, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
      run_div(2'd0, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      run_div(2'd1, 32'd5, 32'd0, "divu_by0");
      run_div(2'd3, 32'd5, 32'd0, "remu_by0");
      run_div(2'd0, 32'hFFFF_FFF0, 32'd0, "div_neg_by0");
      run_div(2'd2, 32'hFFFF_FFF0, 32'd0, "rem_neg_by0");
      run_div(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_div(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      run_div(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "divu_big");
      run_div(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "remu_big");
      run_div(2'd2, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         run_div(2'($urandom_range(0, 3)), ra, rb, "rand");
      end

      run_div(2'd1, 32'd100, 32'd7, "divu_pre_flush");

      // Flush in CALC at cycle 10.
      held      = bus.result;
      bus.op    = 2'd1;
      bus.a     = 32'd1000;
      bus.b     = 32'd3;
      bus.start = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check("flush busy_c11", 32'(bus.busy), 32'd0);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("flush no_done", dones, 0);
      check("flush result_held", bus.result, held);
      @(posedge clk);
      #1;

      // Flush coincident with start in IDLE.
      bus.start = 1'b1;
      bus.flush = 1'b1;
      @(negedge clk);
      check("idle_flush busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      check("idle_flush not_accepted", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;

      // Asynchronous reset at cycle 5 of an op.
      bus.op    = 2'd1;
      bus.a     = 32'd77;
      bus.b     = 32'd5;
      bus.start = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid result", bus.result, 32'd0);
      check("rst_mid busy", 32'(bus.busy), 32'd0);
      check("rst_mid done", 32'(bus.done), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("rst_mid no_done", dones, 0);
      @(posedge clk);
      #1;

      run_div(2'd0, 32'd1000, 32'hFFFF_FFFD, "div_after_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
